// File: rtl/fifo_sync_arb.sv
// ----------------------------------------------------------------------------
// fifo_sync_arb : round-robin producer arbiter, read scheduler and flush
//                 sequencer in front of a shared fifo_sync instance.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_sync_arb #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic              rd_req,
  output logic              rd_ack,
  input  logic              flush,
  output logic              flush_done,
  output logic              fifo_en,
  output logic [DW-1:0]     fifo_data_i,
  output logic              fifo_read,
  output logic [CNTW-1:0]   count,
  output logic              full,
  output logic              empty
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            fifo_en_q, fifo_en_d;
  logic [DW-1:0]   fifo_data_q, fifo_data_d;
  logic            fifo_read_q, fifo_read_d;
  logic            flush_done_q, flush_done_d;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   cand;
  logic [DW-1:0]   grant_data;
  logic            wr_ok, wr_fire, rd_fire, run;

  assign run   = !rst && (state_q == ST_RUN);
  // A same-cycle read never makes room for a write; only the registered count matters.
  assign wr_ok = (count_q < CNTW'(DEPTH));

  // Scan from the farthest candidate back to ptr+1 so the nearest valid one wins.
  always_comb begin
    grant     = '0;
    grant_idx = ptr_q;
    cand      = '0;
    if (run && wr_ok) begin
      for (int k = NREQ; k >= 1; k--) begin
        cand = PW'((int'(ptr_q) + k) % NREQ);
        if (req_valid[cand]) begin
          grant       = '0;
          grant[cand] = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_data = req_data[i*DW +: DW];
    end
  end

  assign req_ready = grant;
  assign wr_fire   = |grant;
  assign rd_ack    = run && rd_req && (count_q != '0);
  assign rd_fire   = rd_ack || (!rst && (state_q == ST_FLUSH) && (count_q != '0));

  always_comb begin
    count_d = count_q;
    if (wr_fire && !rd_fire)      count_d = count_q + CNTW'(1);
    else if (!wr_fire && rd_fire) count_d = count_q - CNTW'(1);

    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      ST_RUN:   if (flush) state_d = ST_FLUSH;
      ST_FLUSH: begin
        // Leave on the edge the count reaches zero (immediately if already empty).
        if (count_d == '0) begin
          state_d      = ST_RUN;
          flush_done_d = 1'b1;
        end
      end
      default:  state_d = ST_RUN;
    endcase

    ptr_d       = wr_fire ? grant_idx : ptr_q;
    fifo_en_d   = wr_fire;
    fifo_data_d = wr_fire ? grant_data : fifo_data_q;
    fifo_read_d = rd_fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      ptr_q        <= PW'(NREQ - 1);
      count_q      <= '0;
      fifo_en_q    <= 1'b0;
      fifo_data_q  <= '0;
      fifo_read_q  <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      fifo_en_q    <= fifo_en_d;
      fifo_data_q  <= fifo_data_d;
      fifo_read_q  <= fifo_read_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign count       = count_q;
  assign full        = (count_q == CNTW'(DEPTH));
  assign empty       = (count_q == '0);
  assign fifo_en     = fifo_en_q;
  assign fifo_data_i = fifo_data_q;
  assign fifo_read   = fifo_read_q;
  assign flush_done  = flush_done_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_sync_arb.sv
// ----------------------------------------------------------------------------
// tb_fifo_sync_arb : directed vector bench for fifo_sync_arb.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fifo_sync_arb;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CNTW  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic              rd_req, rd_ack, flush, flush_done;
  logic              fifo_en, fifo_read, full, empty;
  logic [DW-1:0]     fifo_data_i;
  logic [CNTW-1:0]   count;

  fifo_sync_arb #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rd_req(rd_req), .rd_ack(rd_ack), .flush(flush),
    .flush_done(flush_done), .fifo_en(fifo_en), .fifo_data_i(fifo_data_i),
    .fifo_read(fifo_read), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       rd;
    logic       fl;
    logic [3:0] ready;
    logic       ack;
    logic [4:0] cnt;
    logic       en;
    logic [7:0] data;
    logic       rdq;
    logic       done;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(logic r, logic [3:0] v, logic rd, logic fl, logic [3:0] rdy,
                              logic ack, logic [4:0] c, logic en, logic [7:0] d,
                              logic rdq, logic dn);
    vec_t t;
    t.rst = r; t.valid = v; t.rd = rd; t.fl = fl; t.ready = rdy; t.ack = ack;
    t.cnt = c; t.en = en; t.data = d; t.rdq = rdq; t.done = dn;
    return t;
  endfunction

  task automatic chk(string nm, int row, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL row %0d %s: got %0h expected %0h", row, nm, act, exp);
    end
  endtask

  task automatic apply(vec_t t, int row);
    @(negedge clk);
    rst       = t.rst;
    req_valid = t.valid;
    rd_req    = t.rd;
    flush     = t.fl;
    #1;
    chk("req_ready",   row, 32'(req_ready),   32'(t.ready));
    chk("rd_ack",      row, 32'(rd_ack),      32'(t.ack));
    chk("count",       row, 32'(count),       32'(t.cnt));
    chk("fifo_en",     row, 32'(fifo_en),     32'(t.en));
    chk("fifo_data_i", row, 32'(fifo_data_i), 32'(t.data));
    chk("fifo_read",   row, 32'(fifo_read),   32'(t.rdq));
    chk("flush_done",  row, 32'(flush_done),  32'(t.done));
    chk("full",        row, 32'(full),        32'(t.cnt == 5'd16));
    chk("empty",       row, 32'(empty),       32'(t.cnt == 5'd0));
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = 32'hA3A2A1A0;
    rd_req    = 1'b0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);

    // All producers valid into an empty FIFO: grants rotate 0..3 until full.
    tbl.push_back(mk(1, 4'hF, 0, 0, 4'h0, 0, 0, 0, 8'h00, 0, 0));
    for (int k = 1; k <= 16; k++)
      tbl.push_back(mk(0, 4'hF, 0, 0, 4'(1 << ((k - 1) % 4)), 0, 5'(k - 1), k >= 2,
                       (k >= 2) ? 8'(8'hA0 + (k - 2) % 4) : 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'hF, 0, 0, 4'h0, 0, 16, 1, 8'hA3, 0, 0));
    tbl.push_back(mk(0, 4'hF, 0, 0, 4'h0, 0, 16, 0, 8'hA3, 0, 0));
    // Full with read and writers pending: read only, then read+write keeps count.
    tbl.push_back(mk(0, 4'hF, 1, 0, 4'h0, 1, 16, 0, 8'hA3, 0, 0));
    tbl.push_back(mk(0, 4'hF, 1, 0, 4'h1, 1, 15, 0, 8'hA3, 1, 0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 4'h0, 1, 15, 1, 8'hA0, 1, 0));
    for (int c = 14; c >= 1; c--)
      tbl.push_back(mk(0, 4'h0, 1, 0, 4'h0, 1, 5'(c), 0, 8'hA0, 1, 0));
    // Empty: reads refused.
    tbl.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 0, 0, 8'hA0, 1, 0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 0, 0, 8'hA0, 0, 0));
    // Single write then read: count 0 -> 1 -> 0.
    tbl.push_back(mk(0, 4'h1, 1, 0, 4'h1, 0, 0, 0, 8'hA0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 4'h0, 1, 1, 1, 8'hA0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 0, 0, 8'hA0, 1, 0));
    // Producers 1 and 3 alternate; then only 3.
    tbl.push_back(mk(0, 4'hA, 0, 0, 4'h2, 0, 0, 0, 8'hA0, 0, 0));
    tbl.push_back(mk(0, 4'hA, 0, 0, 4'h8, 0, 1, 1, 8'hA1, 0, 0));
    tbl.push_back(mk(0, 4'hA, 0, 0, 4'h2, 0, 2, 1, 8'hA3, 0, 0));
    tbl.push_back(mk(0, 4'hA, 0, 0, 4'h8, 0, 3, 1, 8'hA1, 0, 0));
    tbl.push_back(mk(0, 4'h8, 0, 0, 4'h8, 0, 4, 1, 8'hA3, 0, 0));
    tbl.push_back(mk(0, 4'h0, 0, 0, 4'h0, 0, 5, 1, 8'hA3, 0, 0));

    foreach (tbl[i]) apply(tbl[i], i);

    // Flush with 5 entries: 5 reads, done pulse, grants resume in RUN.
    tbl.delete();
    tbl.push_back(mk(0, 4'h0, 0, 1, 4'h0, 0, 5, 0, 8'hA3, 0, 0));
    tbl.push_back(mk(0, 4'hF, 1, 0, 4'h0, 0, 5, 0, 8'hA3, 0, 0));
    for (int c = 4; c >= 1; c--)
      tbl.push_back(mk(0, 4'hF, 1, 0, 4'h0, 0, 5'(c), 0, 8'hA3, 1, 0));
    tbl.push_back(mk(0, 4'hF, 0, 0, 4'h1, 0, 0, 0, 8'hA3, 1, 1));
    tbl.push_back(mk(0, 4'h0, 1, 0, 4'h0, 1, 1, 1, 8'hA0, 0, 0));
    // Flush while empty: one FLUSH cycle, then done.
    tbl.push_back(mk(0, 4'h0, 0, 1, 4'h0, 0, 0, 0, 8'hA0, 1, 0));
    tbl.push_back(mk(0, 4'hF, 0, 0, 4'h0, 0, 0, 0, 8'hA0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 0, 0, 4'h2, 0, 0, 0, 8'hA0, 0, 1));
    // Fill to 9, start a flush, reset inside it.
    for (int j = 1; j <= 8; j++)
      tbl.push_back(mk(0, 4'hF, 0, 0, 4'(1 << ((1 + j) % 4)), 0, 5'(j), 1,
                       8'(8'hA0 + j % 4), 0, 0));
    tbl.push_back(mk(0, 4'h0, 0, 1, 4'h0, 0, 9, 1, 8'hA1, 0, 0));
    tbl.push_back(mk(1, 4'hF, 1, 0, 4'h0, 0, 9, 0, 8'hA1, 0, 0));
    tbl.push_back(mk(0, 4'hF, 0, 0, 4'h1, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'h0, 0, 0, 4'h0, 0, 1, 1, 8'hA0, 0, 0));

    foreach (tbl[i]) apply(tbl[i], 100 + i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
